// File: rtl/div3_pkg.sv
// Shared widths, state encoding and counter type for the divide-by-3
// reconstruction path (3*quotient + remainder).
package div3_pkg;

  localparam int Q_W   = 15;
  localparam int R_W   = 2;
  localparam int D_W   = 16;
  localparam int ACC_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] cnt_t;

  // Index of the last quotient bit; the add for this bit is the final one.
  localparam cnt_t LAST_CNT = cnt_t'(Q_W - 1);

endpackage

// File: rtl/mul_by_3_recon_if.sv
// Handshake bundle for the reconstruction block: a quotient/remainder pair
// goes in on the valid/ready input side, and the result with its two flags
// comes out on the valid/ready output side.
interface mul_by_3_recon_if;
  import div3_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] quotient;
  logic [R_W-1:0] remainder;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] dout;
  logic           overflow;
  logic           rem_err;

  // Producer of pairs and consumer of results.
  modport master (
    output in_valid, quotient, remainder, out_ready,
    input  in_ready, out_valid, dout, overflow, rem_err
  );

  // The reconstruction block itself.
  modport slave (
    input  in_valid, quotient, remainder, out_ready,
    output in_ready, out_valid, dout, overflow, rem_err
  );

endinterface

// File: rtl/mul_by_3_recon.sv
// Rebuilds dout = 3*quotient + remainder one quotient bit per cycle.
// The remainder seeds the accumulator, then each set quotient bit i adds
// 3<<i. The result is held in DONE until the consumer takes it.
module mul_by_3_recon
  import div3_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mul_by_3_recon_if.slave  bus
);

  state_t             state;
  state_t             next_state;
  logic [Q_W-1:0]     q_reg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   addend;
  cnt_t               cnt;
  logic               rem_err_reg;
  logic               accept;
  logic               last_step;
  logic               result_taken;

  assign accept       = bus.in_valid && (state == IDLE);
  assign last_step    = (state == BUSY) && (cnt == LAST_CNT);
  assign result_taken = (state == DONE) && bus.out_ready;

  // State register; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept a pair, walk 15 bits, wait for the consumer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept)       next_state = BUSY;
      BUSY: if (last_step)    next_state = DONE;
      DONE: if (result_taken) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Partial product for the current bit: 3 shifted to the bit's weight.
  always_comb begin
    addend = '0;
    if (q_reg[cnt]) begin
      addend = ACC_W'(3) << cnt;
    end
  end

  // Datapath: capture the pair on accept, then accumulate one bit per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      rem_err_reg <= 1'b0;
    end else if (accept) begin
      q_reg       <= bus.quotient;
      acc         <= ACC_W'(bus.remainder);
      cnt         <= '0;
      rem_err_reg <= (bus.remainder == R_W'(3));
    end else if (state == BUSY) begin
      acc <= acc + addend;
      cnt <= cnt + cnt_t'(1);
    end
  end

  // Outputs decode from state only, so out_ready never reaches in_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.dout      = '0;
    bus.overflow  = 1'b0;
    bus.rem_err   = 1'b0;
    if (state == DONE) begin
      bus.dout     = acc[D_W-1:0];
      bus.overflow = acc[ACC_W-1];
      bus.rem_err  = rem_err_reg;
    end
  end

endmodule

// File: doc/mul_by_3_recon.md
MUL_BY_3_RECON -- requirements
Module: mul_by_3_recon

Interface
REQ-001 The block SHALL have no parameters; all widths come from the shared package (Q_W=15, R_W=2, D_W=16).
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  quotient/remainder pair offered.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 quotient  input  15  quotient from the divide-by-3 path.
REQ-007 remainder  input  2  remainder from the divide-by-3 path; legal values are 0 to 2.
REQ-008 out_valid  output  1  reconstructed result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 dout  output  16  low 16 bits of 3*quotient+remainder.
REQ-011 overflow  output  1  set when 3*quotient+remainder exceeds 65535.
REQ-012 rem_err  output  1  set when the captured remainder equals 3.

Function
REQ-013 The block SHALL compute dout = 3*quotient + remainder bit-serially, using a 17-bit accumulator and one quotient bit per cycle.
REQ-014 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE: in_ready=1 and out_valid=0.
REQ-016 In BUSY and DONE: in_ready=0; a new pair is never accepted while a result is in flight.
REQ-017 Accept condition: in_valid && in_ready on a rising edge.
REQ-018 On accept, the block SHALL:
- capture quotient;
- load acc=remainder (zero-extended);
- latch rem_err=(remainder==3);
- clear cnt to 0;
- move to BUSY.
REQ-019 On each BUSY edge, if quotient bit cnt is 1, the block SHALL add (3<<cnt) to acc modulo 2^17, then increment cnt.
REQ-020 The BUSY edge with cnt==14 SHALL perform the final add and move to DONE; BUSY therefore lasts exactly 15 edges.
REQ-021 Latency: out_valid SHALL rise on the 15th rising edge after the accepting edge.
REQ-022 In DONE the block SHALL hold these values constant until a handshake:
- out_valid=1;
- dout=acc[15:0];
- overflow=acc[16];
- rem_err as latched.
REQ-023 On out_valid && out_ready, the block SHALL return to IDLE; out_valid deasserts on that edge.
REQ-024 in_ready SHALL go high on the same edge as REQ-023; there is no combinational path from out_ready to in_ready.
REQ-025 While out_ready is low in DONE, the result SHALL be held indefinitely with no loss and no change.
REQ-026 Changes on quotient and remainder after the accepting edge SHALL have no effect on the result.
REQ-027 A remainder of 3 SHALL still be reconstructed arithmetically, with rem_err=1 flagged alongside the result.
REQ-028 Maximum legal input (q=21845, r=0) SHALL give dout=65535 with overflow=0.
REQ-029 Any larger sum SHALL set overflow=1, with dout holding the truncated value.

Reset
REQ-030 rst_n low SHALL asynchronously force the following, including mid-BUSY or mid-DONE; the in-flight result is discarded:
- state=IDLE;
- acc=0 and cnt=0;
- in_ready=1 after release;
- out_valid=0, dout=0, overflow=0, rem_err=0.
REQ-031 No accept SHALL occur while rst_n is low; the first accept SHALL be possible on the first rising edge after release.

Structure
REQ-032 The shared package div3_pkg SHALL hold:
- Q_W, R_W and D_W;
- ACC_W=17;
- the state enum {IDLE, BUSY, DONE};
- the cnt type (4 bits).
REQ-033 The block SHALL be a single module with no sub-module; the FSM, counter and accumulator are small enough to keep inline.
REQ-034 All flops SHALL use the async active-low reset on clk only.

Verification
REQ-035 Directed scenarios the bench SHALL cover:
- Basic: q=5, r=1, out_ready=1 -> dout=16, overflow=0, rem_err=0; out_valid on the 15th edge after accept.
- Round trip: q=33, r=1 -> dout=100. q=2, r=1 -> 7. q=0, r=2 -> 2. q=0, r=0 -> 0.
- Boundary: q=21845, r=0 -> dout=65535, overflow=0. q=21845, r=1 -> dout=0, overflow=1. q=32767, r=2 -> dout=32767, overflow=1.
- Illegal remainder: q=4, r=3 -> dout=15, rem_err=1. On the next transaction q=4, r=0 -> dout=12, rem_err=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0. Raise out_ready -> one handshake, then in_ready=1 on the next cycle. Input changes during BUSY -> result unaffected.
- Reset: assert rst_n=0 at BUSY cnt=7 -> immediately out_valid=0, dout=0, and in_ready=1 after release. A new pair q=1, r=0 -> dout=3.
